// File: rtl/audio_pkg.sv
// ============================================================================
// audio_pkg : shared FSM states, format codes and default widths for audio IO
// Revision  : 1.0
// ============================================================================
`default_nettype none

package audio_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2
    } rx_state_t;

    localparam logic FMT_I2S = 1'b0;
    localparam logic FMT_LJ  = 1'b1;

    localparam int AUDIO_DATA_W = 16;
    localparam int AUDIO_SLOT_W = 32;

endpackage

`default_nettype wire

// File: rtl/audio_edge_sync.sv
// ============================================================================
// audio_edge_sync : 2-FF synchroniser with rise/fall/any-edge strobes
// Revision        : 1.0
// ============================================================================
`default_nettype none

module audio_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall,
    output logic any_edge
);

    logic [1:0] meta;
    logic       prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 2'b00;
            prev <= 1'b0;
        end else begin
            meta <= {meta[0], din};
            prev <= meta[1];
        end
    end

    assign sync     = meta[1];
    assign rise     = meta[1] & ~prev;
    assign fall     = ~meta[1] & prev;
    assign any_edge = meta[1] ^ prev;

endmodule

`default_nettype wire

// File: rtl/audio_i2s_rx.sv
// ============================================================================
// audio_i2s_rx : oversampled I2S / left-justified stereo receiver
//                optional saturating slot-error counter: AUDIO_RX_ERR_CNT_EN
// Revision     : 1.0
// ============================================================================
`default_nettype none

module audio_i2s_rx
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int SLOT_W = AUDIO_SLOT_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fmt_lj,
    input  logic              BCLK,
    input  logic              LRCLK,
    input  logic              ADCDAT,
    output logic [DATA_W-1:0] left,
    output logic [DATA_W-1:0] right,
    output logic              sample_valid,
    output logic              slot_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int                BW       = $clog2(SLOT_W + 2);
    localparam logic [BW-1:0]     SLOT_LEN = BW'(SLOT_W);
    localparam logic [DATA_W-1:0] MSB_ONE  = {1'b1, {(DATA_W-1){1'b0}}};

    logic bclk_rise, lr_s;
    logic bclk_unused_sync, bclk_unused_fall, bclk_unused_any;
    logic lr_unused_rise, lr_unused_fall, lr_unused_any;

    audio_edge_sync u_bclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (BCLK),
        .sync     (bclk_unused_sync),
        .rise     (bclk_rise),
        .fall     (bclk_unused_fall),
        .any_edge (bclk_unused_any)
    );

    audio_edge_sync u_lrclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (LRCLK),
        .sync     (lr_s),
        .rise     (lr_unused_rise),
        .fall     (lr_unused_fall),
        .any_edge (lr_unused_any)
    );

    logic [1:0] dat_meta;
    logic       dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dat_meta <= 2'b00;
        else        dat_meta <= {dat_meta[0], ADCDAT};
    end
    assign dat = dat_meta[1];

    rx_state_t         state, state_d;
    logic              lr_q, lr_primed, ws_edge;
    logic              ch, have_l;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg, ptr, hold_l;

    // The first strobe after reset only primes lr_q, so a static LRCLK level is not an edge.
    assign ws_edge = bclk_rise & lr_primed & (lr_s != lr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (ws_edge)
            state_d = (fmt_lj == FMT_LJ) ? SHIFT : ALIGN;
        else if (bclk_rise && state == ALIGN)
            state_d = SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_q         <= 1'b0;
            lr_primed    <= 1'b0;
            ch           <= 1'b0;
            have_l       <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
            ptr          <= '0;
            hold_l       <= '0;
            left         <= '0;
            right        <= '0;
            sample_valid <= 1'b0;
            slot_err     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            slot_err     <= 1'b0;
            if (bclk_rise) begin
                lr_q      <= lr_s;
                lr_primed <= 1'b1;
                if (ws_edge) begin
                    if (state != HUNT) begin
                        slot_err <= (bit_cnt != SLOT_LEN);
                        if (!ch) begin
                            hold_l <= shreg;
                            have_l <= 1'b1;
                        end else begin
                            if (have_l) begin
                                left         <= hold_l;
                                right        <= shreg;
                                sample_valid <= 1'b1;
                            end
                            have_l <= 1'b0;
                        end
                    end
                    ch      <= lr_s;
                    bit_cnt <= BW'(1);
                    // LJ: this bit is the new MSB; I2S: it is the discarded delay bit.
                    if (fmt_lj == FMT_LJ) begin
                        shreg <= dat ? MSB_ONE : '0;
                        ptr   <= MSB_ONE >> 1;
                    end else begin
                        shreg <= '0;
                        ptr   <= MSB_ONE;
                    end
                end else if (state != HUNT) begin
                    if (bit_cnt != '1) bit_cnt <= bit_cnt + BW'(1);
                    if (dat) shreg <= shreg | ptr;
                    ptr <= ptr >> 1;
                end
            end
        end
    end

`ifdef AUDIO_RX_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= '0;
        else if (slot_err && err_cnt_q != '1)
            err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_i2s_rx.sv
// ============================================================================
// tb_audio_i2s_rx : directed self-checking bench for audio_i2s_rx
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_audio_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fmt_lj = 1'b0;
    logic        BCLK = 1'b0;
    logic        LRCLK = 1'b1;
    logic        ADCDAT = 1'b0;
    logic [15:0] left, right;
    logic        sample_valid, slot_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [15:0] cap_l = '0, cap_r = '0;
    logic [7:0]  exp_sat, exp_one;

    always #5 clk = ~clk;

    audio_i2s_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fmt_lj       (fmt_lj),
        .BCLK         (BCLK),
        .LRCLK        (LRCLK),
        .ADCDAT       (ADCDAT),
        .left         (left),
        .right        (right),
        .sample_valid (sample_valid),
        .slot_err     (slot_err),
        .err_count    (err_count)
    );

    always @(negedge clk) begin
        if (!rst_n) begin
            n_valid = 0;
            n_err   = 0;
        end else begin
            if (sample_valid) begin
                n_valid = n_valid + 1;
                cap_l   = left;
                cap_r   = right;
            end
            if (slot_err) n_err = n_err + 1;
        end
    end

    `define CHECK(tag, obs, exp) \
        checks = checks + 1; \
        assert ((obs) === (exp)) else begin \
            errors = errors + 1; \
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
        end

    function automatic logic bitval(input logic [15:0] d, input int i, input logic lj);
        if (lj) return (i < 16) ? d[15 - i] : 1'b0;
        else    return (i >= 1 && i <= 16) ? d[16 - i] : 1'b0;
    endfunction

    task automatic send_range(input logic lr, input logic [15:0] d,
                              input int lo, input int hi, input logic lj);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            BCLK   = 1'b0;
            LRCLK  = lr;
            ADCDAT = bitval(d, i, lj);
            repeat (4) @(negedge clk);
            BCLK = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] d, input int n, input logic lj);
        send_range(lr, d, 0, n - 1, lj);
    endtask

    task automatic reset_dut(input logic lr_idle);
        @(negedge clk);
        rst_n = 1'b0;
        BCLK  = 1'b0;
        LRCLK = lr_idle;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
        #1;
    endtask

    initial begin
`ifdef AUDIO_RX_ERR_CNT_EN
        exp_sat = 8'd255;
        exp_one = 8'd1;
`else
        exp_sat = 8'd0;
        exp_one = 8'd0;
`endif
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        `CHECK("rst_left", left, 16'h0000)
        `CHECK("rst_right", right, 16'h0000)
        `CHECK("rst_valid", sample_valid, 1'b0)
        `CHECK("rst_slot_err", slot_err, 1'b0)
        `CHECK("rst_err_count", err_count, 8'd0)

        // 1: I2S frame, BCLK paused mid-left-slot
        fmt_lj = 1'b0;
        reset_dut(1'b1);
        send_slot(1'b1, 16'h0000, 4, 1'b0);
        send_range(1'b0, 16'h1234, 0, 9, 1'b0);
        repeat (40) @(negedge clk);
        send_range(1'b0, 16'h1234, 10, 31, 1'b0);
        send_slot(1'b1, 16'hABCD, 32, 1'b0);
        send_slot(1'b0, 16'h0000, 2, 1'b0);
        settle();
        `CHECK("t1_nvalid", n_valid, 1)
        `CHECK("t1_left", cap_l, 16'h1234)
        `CHECK("t1_right", cap_r, 16'hABCD)
        `CHECK("t1_nerr", n_err, 0)
        `CHECK("t1_hold_left", left, 16'h1234)

        // 2: LJ frame, then the same LJ stream decoded as I2S
        fmt_lj = 1'b1;
        reset_dut(1'b1);
        send_slot(1'b1, 16'h0000, 4, 1'b1);
        send_slot(1'b0, 16'h8001, 32, 1'b1);
        send_slot(1'b1, 16'h7FFF, 32, 1'b1);
        send_slot(1'b0, 16'h0000, 2, 1'b1);
        settle();
        `CHECK("t2_nvalid", n_valid, 1)
        `CHECK("t2_left", cap_l, 16'h8001)
        `CHECK("t2_right", cap_r, 16'h7FFF)
        fmt_lj = 1'b0;
        reset_dut(1'b1);
        send_slot(1'b1, 16'h0000, 4, 1'b1);
        send_slot(1'b0, 16'h8001, 32, 1'b1);
        send_slot(1'b1, 16'h7FFF, 32, 1'b1);
        send_slot(1'b0, 16'h0000, 2, 1'b1);
        settle();
        `CHECK("t2_i2s_left", cap_l, 16'h0002)
        `CHECK("t2_i2s_right", cap_r, 16'hFFFE)

        // 3: 12-BCLK left slot of all ones
        fmt_lj = 1'b1;
        reset_dut(1'b1);
        send_slot(1'b1, 16'h0000, 4, 1'b1);
        send_slot(1'b0, 16'hFFF0, 12, 1'b1);
        send_slot(1'b1, 16'h1111, 32, 1'b1);
        send_slot(1'b0, 16'h0000, 2, 1'b1);
        settle();
        `CHECK("t3_left", cap_l, 16'hFFF0)
        `CHECK("t3_right", cap_r, 16'h1111)
        `CHECK("t3_nerr", n_err, 1)
        `CHECK("t3_err_count", err_count, exp_one)

        // 4: reset in the middle of a left slot
        send_range(1'b0, 16'h1111, 0, 9, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        `CHECK("t4_rst_left", left, 16'h0000)
        `CHECK("t4_rst_err_count", err_count, 8'd0)
        rst_n = 1'b1;
        send_range(1'b0, 16'h1111, 10, 31, 1'b1);
        send_slot(1'b1, 16'h2222, 32, 1'b1);
        send_slot(1'b0, 16'h3333, 32, 1'b1);
        send_slot(1'b1, 16'h4444, 32, 1'b1);
        send_slot(1'b0, 16'h5555, 32, 1'b1);
        #1;
        `CHECK("t4_nvalid_mid", n_valid, 1)
        `CHECK("t4_left_mid", cap_l, 16'h3333)
        `CHECK("t4_right_mid", cap_r, 16'h4444)
        send_slot(1'b1, 16'h6666, 32, 1'b1);
        send_slot(1'b0, 16'h0000, 2, 1'b1);
        settle();
        `CHECK("t4_nvalid", n_valid, 2)
        `CHECK("t4_left", cap_l, 16'h5555)
        `CHECK("t4_right", cap_r, 16'h6666)
        `CHECK("t4_nerr", n_err, 0)

        // 5: stimulus starts in the middle of a right slot
        reset_dut(1'b1);
        send_range(1'b1, 16'h7777, 12, 31, 1'b1);
        send_slot(1'b0, 16'h0F0F, 32, 1'b1);
        send_slot(1'b1, 16'hF0F0, 32, 1'b1);
        send_slot(1'b0, 16'h0000, 2, 1'b1);
        settle();
        `CHECK("t5_nvalid", n_valid, 1)
        `CHECK("t5_left", cap_l, 16'h0F0F)
        `CHECK("t5_right", cap_r, 16'hF0F0)

        // 6: 300 four-bit slots
        reset_dut(1'b1);
        send_slot(1'b1, 16'h0000, 2, 1'b1);
        for (int k = 0; k < 300; k++)
            send_slot(k[0], 16'hA000, 4, 1'b1);
        send_slot(1'b0, 16'h0000, 1, 1'b1);
        settle();
        `CHECK("t6_nerr", n_err, 300)
        `CHECK("t6_err_count", err_count, exp_sat)
        `CHECK("t6_left", cap_l, 16'hA000)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
